// File: rtl/baccarat_pkg.sv
// Shared card types, constants and the Baccarat per-card value function
// used by the hand registers and the player/banker decision logic.
package baccarat_pkg;

  typedef logic [3:0] card_t;

  localparam card_t CARD_NONE  = 4'd0;
  localparam card_t CARD_ACE   = 4'd1;
  localparam card_t CARD_KING  = 4'd13;
  localparam int    HAND_SLOTS = 3;

  // Pip cards score their face value; tens and court cards (and empty slots) score 0.
  function automatic logic [3:0] card_value(input card_t code);
    if (code >= CARD_ACE && code <= 4'd9) return code;
    else return 4'd0;
  endfunction

endpackage

// File: rtl/deal_hand_card_source.sv
// Free-running card code source: wraps CARD_MAX -> CARD_MIN every clock
// unless hold_i freezes it.
module card_source
  import baccarat_pkg::*;
#(
  parameter int CARD_MIN = 1,
  parameter int CARD_MAX = 13,
  parameter int START    = 1
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  hold_i,
  output card_t value_o
);

  localparam card_t MinCode   = card_t'(CARD_MIN);
  localparam card_t MaxCode   = card_t'(CARD_MAX);
  localparam card_t StartCode = card_t'(START);

  card_t value_q, value_d;

  // The >= compare keeps the source inside the legal range even from a bad value.
  always_comb begin
    value_d = value_q;
    if (!hold_i) begin
      if (value_q >= MaxCode || value_q < MinCode) value_d = MinCode;
      else value_d = value_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) value_q <= StartCode;
    else       value_q <= value_d;
  end

  assign value_o = value_q;

endmodule

// File: rtl/deal_hand.sv
// Three-slot Baccarat hand: latches the card source into the next empty slot
// on each deal strobe and reports the slots, fill state and hand score.
module deal_hand
  import baccarat_pkg::*;
#(
  parameter int CARD_MIN = 1,
  parameter int CARD_MAX = 13,
  parameter int START    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hold,
  input  logic       deal,
  input  logic       clear,
  output logic [3:0] card0,
  output logic [3:0] card1,
  output logic [3:0] card2,
  output logic [2:0] valid,
  output logic [1:0] count,
  output logic       full,
  output logic       drop,
  output logic [3:0] score
);

  card_t                 srcValue;
  card_t                 slot_q [HAND_SLOTS];
  card_t                 slot_d [HAND_SLOTS];
  logic [HAND_SLOTS-1:0] valid_q, valid_d;
  logic [1:0]            count_q, count_d;
  logic                  drop_q, drop_d;
  logic [4:0]            sum;
  logic [4:0]            scoreFull;

  card_source #(
    .CARD_MIN(CARD_MIN),
    .CARD_MAX(CARD_MAX),
    .START   (START)
  ) u_source (
    .clk    (clk),
    .reset  (reset),
    .hold_i (hold),
    .value_o(srcValue)
  );

  // Clear takes priority over deal; a deal on a full hand only raises drop.
  always_comb begin
    slot_d  = slot_q;
    valid_d = valid_q;
    count_d = count_q;
    drop_d  = 1'b0;
    if (clear) begin
      slot_d  = '{default: CARD_NONE};
      valid_d = '0;
      count_d = '0;
    end else if (deal) begin
      if (count_q == 2'd3) begin
        drop_d = 1'b1;
      end else begin
        for (int i = 0; i < HAND_SLOTS; i++) begin
          if (count_q == 2'(i)) begin
            slot_d[i]  = srcValue;
            valid_d[i] = 1'b1;
          end
        end
        count_d = count_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q  <= '{default: CARD_NONE};
      valid_q <= '0;
      count_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      valid_q <= valid_d;
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

  // Sum is at most 27, so a mod-10 needs only two compare/subtract steps.
  always_comb begin
    sum = {1'b0, card_value(slot_q[0])} + {1'b0, card_value(slot_q[1])}
        + {1'b0, card_value(slot_q[2])};
    if (sum >= 5'd20)      scoreFull = sum - 5'd20;
    else if (sum >= 5'd10) scoreFull = sum - 5'd10;
    else                   scoreFull = sum;
  end

  assign card0 = slot_q[0];
  assign card1 = slot_q[1];
  assign card2 = slot_q[2];
  assign valid = valid_q;
  assign count = count_q;
  assign full  = (count_q == 2'd3);
  assign drop  = drop_q;
  assign score = scoreFull[3:0];

endmodule
